// File: rtl/comms_tx_arbiter_pkg.sv
// Shared definitions for the comms TX arbiters: FSM states, default header tag
// and the header-byte builder.
package comms_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_e;

  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

  function automatic logic [7:0] header_byte(input logic [3:0] tag, input logic [3:0] id);
    return {tag, id};
  endfunction

endpackage

// File: rtl/comms_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping
// modulo N (last_i itself has the lowest priority).
module comms_tx_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return s[IW-1:0];
  endfunction

  // Scan from the far end so the nearest requester after last_i is written last and wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[wrap_idx(last_i, k)]) begin
        any_o = 1'b1;
        idx_o = wrap_idx(last_i, k);
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/comms_tx_arbiter.sv
// Round-robin packet arbiter sharing one byte-wide comms TX fifo: header byte
// with the source ID, then the granted requester's bytes, with stall timeout.
module comms_tx_arbiter
  import comms_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] HEADER_TAG = HEADER_TAG_DEFAULT,
  parameter int         TIMEOUT    = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 fifo_write,
  output logic [7:0]           fifo_data,
  input  logic                 fifo_full,
  output logic                 grant_valid,
  output logic [3:0]           grant_id,
  output logic                 timeout
);

  localparam int             IW        = $clog2(NUM_REQ);
  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  STALL_MAX = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  LAST_RST  = IW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          gvalid_q, gvalid_d;
  logic [CW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;

  logic          pick_any_s;
  logic [IW-1:0] pick_idx_s;
  logic          gnt_valid_s;
  logic          gnt_last_s;
  logic [7:0]    gnt_data_s;
  logic          accept_s;
  logic [3:0]    gid_s;

  comms_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .any_o  (pick_any_s),
    .idx_o  (pick_idx_s)
  );

  assign gnt_valid_s = req_valid[grant_q];
  assign gnt_last_s  = req_last[grant_q];
  assign gnt_data_s  = req_data[8*int'(grant_q) +: 8];
  assign accept_s    = (state_q == ST_STREAM) && gnt_valid_s && !fifo_full;

  // Zero-extend the grant index onto the fixed 4-bit ID field.
  always_comb begin
    gid_s           = 4'h0;
    gid_s[IW-1:0]   = grant_q;
  end

  // Fifo/requester handshake: only the granted requester is ever ready, never while full.
  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_data  = 8'h00;
    case (state_q)
      ST_HEADER: begin
        fifo_data  = header_byte(HEADER_TAG, gid_s);
        fifo_write = !fifo_full;
      end
      ST_STREAM: begin
        req_ready[grant_q] = !fifo_full;
        fifo_write         = gnt_valid_s && !fifo_full;
        fifo_data          = gnt_data_s;
      end
      default: begin
        fifo_write = 1'b0;
      end
    endcase
  end

  // Next-state: arbitration, packet end and stall timeout.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    gvalid_d  = gvalid_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_any_s) begin
          grant_d  = pick_idx_s;
          gvalid_d = 1'b1;
          state_d  = ST_HEADER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        stall_d = '0;
        if (!fifo_full) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_STREAM: begin
        if (accept_s) begin
          stall_d = '0;
          if (gnt_last_s) begin
            state_d  = ST_IDLE;
            gvalid_d = 1'b0;
            last_d   = grant_q;
          end else begin
            state_d = ST_STREAM;
          end
        end else if (!gnt_valid_s) begin
          // Truncated packet stays in the fifo; the next header marks the break.
          if (stall_q == STALL_MAX) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            gvalid_d  = 1'b0;
            last_d    = grant_q;
            stall_d   = '0;
          end else begin
            stall_d = stall_q + CW'(1);
          end
        end else begin
          stall_d = stall_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gvalid_d = 1'b0;
        stall_d  = '0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      gvalid_q  <= 1'b0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      gvalid_q  <= gvalid_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_valid = gvalid_q;
  assign grant_id    = gid_s;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_comms_tx_arbiter.sv
// Scoreboard bench: a packet-level round-robin model predicts the fifo byte
// stream; a monitor compares every fifo write and handshake rule.
module tb_comms_tx_arbiter;

  localparam int         NR  = 4;
  localparam int         TO  = 16;
  localparam logic [3:0] TAG = 4'hA;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_write;
  logic [7:0]      fifo_data;
  logic            fifo_full;
  logic            grant_valid;
  logic [3:0]      grant_id;
  logic            timeout;

  always #5 clock = ~clock;

  comms_tx_arbiter #(.NUM_REQ(NR), .HEADER_TAG(TAG), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_write  (fifo_write),
    .fifo_data   (fifo_data),
    .fifo_full   (fifo_full),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  int checks = 0;
  int failures = 0;

  // Entry: {abandon, last, data}. An abandon entry means "stop sending mid-packet".
  logic [9:0] pend_q[NR][$];
  logic [9:0] new_q[NR][$];
  logic [7:0] exp_q[$];
  int         wr_cyc[$];

  int            last_m = NR - 1;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            n_to = 0;
  int            gv_fall_cyc = -1;
  logic          gv_prev = 1'b0;
  logic [NR-1:0] acc = '0;
  int            gap[NR];
  int            abn[NR];
  int            acc_cnt[NR];
  int            gaps_en = 0;
  int            full_mode = 0;
  int            force_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_entry(input int i, input logic [9:0] e);
    pend_q[i].push_back(e);
    new_q[i].push_back(e);
  endtask

  task automatic add_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) begin
      add_entry(i, {1'b0, (b == len - 1), 8'($urandom)});
    end
  endtask

  // Reference: serve newly loaded packets round-robin after the last owner.
  task automatic model_run();
    bit         more;
    int         pick;
    int         cand;
    logic [9:0] e;
    more = 1'b1;
    while (more) begin
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
        cand = (last_m + k) % NR;
        if (pick < 0 && new_q[cand].size() > 0) pick = cand;
      end
      if (pick < 0) begin
        more = 1'b0;
      end else begin
        exp_q.push_back({TAG, 4'(pick)});
        do begin
          e = new_q[pick].pop_front();
          if (!e[9]) exp_q.push_back(e[7:0]);
        end while (!e[8] && !e[9] && new_q[pick].size() > 0);
        last_m = pick;
      end
    end
  endtask

  function automatic bit all_empty();
    bit r;
    r = (exp_q.size() == 0);
    for (int i = 0; i < NR; i++) if (pend_q[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  // One clock of requester/fifo behaviour; accepts are sampled 1ns after the drive.
  task automatic step();
    logic [9:0] e;
    logic       v;
    logic [7:0] d;
    logic       l;
    @(negedge clock);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        e = pend_q[i].pop_front();
        acc_cnt[i]++;
        gap[i] = (gaps_en != 0 && !e[8] && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      v = 1'b0;
      d = 8'($urandom);
      l = 1'($urandom);
      if (pend_q[i].size() > 0) begin
        e = pend_q[i][0];
        if (e[9]) begin
          abn[i]++;
          if (abn[i] >= 30) begin
            void'(pend_q[i].pop_front());
            abn[i] = 0;
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else begin
          v = 1'b1;
          d = e[7:0];
          l = e[8];
        end
      end
      req_valid[i]       = v;
      req_data[8*i +: 8] = d;
      req_last[i]        = l;
    end
    if (force_cnt > 0) begin
      fifo_full = 1'b1;
      force_cnt--;
    end else begin
      fifo_full = (full_mode != 0) && ($urandom_range(0, 3) == 0);
    end
    #1;
    for (int i = 0; i < NR; i++) acc[i] = req_valid[i] & req_ready[i];
    if (|acc) last_acc_cyc = cyc;
  endtask

  task automatic run_until_done(input string name);
    int n;
    n = 0;
    while (!all_empty() && n < 3000) begin
      step();
      n++;
    end
    chk(name, (n < 3000), 1);
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_fifo_write"}, fifo_write, 0);
    chk({tag, "_fifo_data"}, fifo_data, 0);
    chk({tag, "_grant_valid"}, grant_valid, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // Monitor: every fifo write is popped against the model and handshake rules checked.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      #2;
      if (reset_n) begin
        if (fifo_write) begin
          wr_cyc.push_back(cyc);
          chk("no_write_when_full", fifo_full, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: actual=%0h required=none", fifo_data);
          end else begin
            chk("fifo_byte", fifo_data, exp_q.pop_front());
          end
        end
        if (fifo_full) chk("ready_low_when_full", req_ready, 0);
        if (grant_valid) chk("ready_only_granted", req_ready & ~(NR'(1) << grant_id), 0);
        else chk("ready_low_idle", req_ready, 0);
        if (timeout) begin
          n_to++;
          chk("timeout_drops_grant", grant_valid, 0);
          chk("timeout_delay", cyc - last_acc_cyc - 1, TO);
        end
        if (gv_prev && !grant_valid) gv_fall_cyc = cyc;
        gv_prev = grant_valid;
      end else begin
        gv_prev = 1'b0;
      end
    end
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      gap[i] = 0; abn[i] = 0; acc_cnt[i] = 0;
    end
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single packet back to back: A0,11,22,33 then grant drops.
    wr_cyc.delete();
    add_entry(0, {2'b00, 8'h11});
    add_entry(0, {2'b00, 8'h22});
    add_entry(0, {2'b01, 8'h33});
    model_run();
    run_until_done("single_done");
    chk("single_write_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      chk("single_consecutive", wr_cyc[3] - wr_cyc[0], 3);
      chk("single_grant_drop", gv_fall_cyc, wr_cyc[3] + 1);
    end

    // Fairness: all four requesting one-byte packets, requester 0 twice.
    for (int i = 0; i < NR; i++) add_pkt(i, 1);
    add_pkt(0, 1);
    model_run();
    run_until_done("fair_done");

    // Simultaneous: 0 and 2 arrive while 1 streams; 2 must follow 1.
    add_pkt(1, 4);
    model_run();
    step();
    step();
    add_pkt(0, 1);
    add_pkt(2, 1);
    model_run();
    run_until_done("simul_done");

    // Backpressure during HEADER and mid-STREAM.
    add_pkt(3, 5);
    model_run();
    step();
    force_cnt = 5;
    repeat (8) step();
    force_cnt = 5;
    run_until_done("bp_done");

    // Randomised traffic with stalls and random fifo_full.
    gaps_en = 1;
    for (int p = 0; p < 25; p++) begin
      full_mode = int'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          add_pkt(i, int'($urandom_range(1, 5)));
          if ($urandom_range(0, 1) == 1) add_pkt(i, int'($urandom_range(1, 5)));
        end
      end
      add_pkt(int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 3)));
      model_run();
      run_until_done("random_done");
    end
    gaps_en = 0;
    full_mode = 0;

    // Timeout: requester 2 abandons its packet, 3 is waiting.
    add_pkt(1, 1);
    model_run();
    run_until_done("pre_to_done");
    add_entry(2, {2'b00, 8'h5C});
    add_entry(2, 10'h200);
    add_pkt(3, 2);
    model_run();
    run_until_done("to_done");
    chk("timeout_count", n_to, 1);

    // Reset mid-STREAM of requester 1.
    add_pkt(1, 6);
    model_run();
    acc_cnt[1] = 0;
    n = 0;
    while (acc_cnt[1] < 2 && n < 200) begin
      step();
      n++;
    end
    chk("reset_reached_stream", (n < 200), 1);
    #3;
    reset_n   = 1'b0;
    req_valid = '0;
    acc       = '0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      pend_q[i].delete();
      new_q[i].delete();
      gap[i] = 0;
      abn[i] = 0;
    end
    #1;
    check_reset_outputs("midreset");
    step();
    reset_n = 1'b1;
    last_m = NR - 1;
    add_pkt(1, 1);
    add_pkt(0, 1);
    model_run();
    run_until_done("post_reset_done");

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("timeout_total", n_to, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
